// File: rtl/fp_pkg.sv
// Shared FPU constants and FSM state type for the single-precision units.
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;
  localparam int unsigned QB    = MAN_W + 2;
  localparam int unsigned W     = EXP_W + MAN_W + 1;

  localparam logic [W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [W-1:0] INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    POST
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero count; an all-zero input reports W.
module fp_lzc #(
  parameter int unsigned W  = 24,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  v,
  output logic [CW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && v[W-1-i]) begin
        cnt   = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Iterative single-precision divider, restoring radix-2, truncating.
// FP_DIV_SPECIAL_EN enables NaN/infinity decoding of exp=all-ones operands.
module fp_divider_seq #(
  parameter int unsigned EXP_W = fp_pkg::EXP_W,
  parameter int unsigned MAN_W = fp_pkg::MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   operand1,
  input  logic [EXP_W+MAN_W:0]   operand2,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   div_zero
);

  import fp_pkg::*;

  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned QB = MAN_W + 2;
  localparam int unsigned SE = EXP_W + 2;
  localparam int unsigned LZ = $clog2(MW + 1);
  localparam int unsigned CW = $clog2(QB);

  localparam logic [SE-1:0]    BIASV = SE'((1 << (EXP_W - 1)) - 1);
  localparam logic [SE-1:0]    EMAXV = SE'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [EXP_W-1:0] EZERO = '0;
  localparam logic [MAN_W-1:0] MZERO = '0;

  state_t state, state_nx;

  logic [W-1:0]     op1, op2;
  logic [EXP_W-1:0] e1, e2;
  logic [MW-1:0]    m1raw, m2raw, m1n, m2n, dvs;
  logic [LZ-1:0]    lz1, lz2;
  logic [SE-1:0]    ex1, ex2, exp_prep, exp_q, exp_adj;
  logic [MW:0]      rem, diff;
  logic             ge;
  logic [QB-1:0]    q;
  logic [MAN_W-1:0] mant;
  logic [CW-1:0]    cnt;
  logic             sign_q, z1, z2, z1_q, z2_q, done_q;
  logic             accept, ld_prep, step, fin;
  logic [W-1:0]     res_nx;
  logic             ovf_nx, unf_nx, dz_nx;

`ifdef FP_DIV_SPECIAL_EN
  logic             e1ff, e2ff, nan1, nan2, inf1, inf2;
  logic             spec_hit, spec_q;
  logic [W-1:0]     spec_val, spec_res;
`endif

  fp_lzc #(.W(MW), .CW(LZ)) u_lzc1 (.v(m1raw), .cnt(lz1));
  fp_lzc #(.W(MW), .CW(LZ)) u_lzc2 (.v(m2raw), .cnt(lz2));

  // Operand decode: subnormals get exponent 1 and are normalized here.
  always_comb begin
    e1       = op1[W-2:MAN_W];
    e2       = op2[W-2:MAN_W];
    m1raw    = {|e1, op1[MAN_W-1:0]};
    m2raw    = {|e2, op2[MAN_W-1:0]};
    z1       = ~|m1raw;
    z2       = ~|m2raw;
    m1n      = m1raw << lz1;
    m2n      = m2raw << lz2;
    ex1      = (e1 == EZERO) ? SE'(1) : SE'(e1);
    ex2      = (e2 == EZERO) ? SE'(1) : SE'(e2);
    ex1      = ex1 - SE'(lz1);
    ex2      = ex2 - SE'(lz2);
    exp_prep = ex1 - ex2 + BIASV;
  end

`ifdef FP_DIV_SPECIAL_EN
  always_comb begin
    e1ff     = &e1;
    e2ff     = &e2;
    nan1     = e1ff && (|op1[MAN_W-1:0]);
    nan2     = e2ff && (|op2[MAN_W-1:0]);
    inf1     = e1ff && !(|op1[MAN_W-1:0]);
    inf2     = e2ff && !(|op2[MAN_W-1:0]);
    spec_hit = e1ff || e2ff || (z1 && z2);
    if (nan1 || nan2 || (inf1 && inf2) || (z1 && z2))
      spec_val = {1'b0, EONES, 1'b1, MZERO[MAN_W-2:0]};
    else if (inf1)
      spec_val = {op1[W-1] ^ op2[W-1], EONES, MZERO};
    else
      spec_val = {op1[W-1] ^ op2[W-1], EZERO, MZERO};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = DIV;
      DIV:     if (cnt == '0) state_nx = POST;
      POST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = done_q;
    accept  = (state == IDLE) && start;
    ld_prep = (state == PREP);
    step    = (state == DIV);
    fin     = (state == POST);
  end

  always_comb begin
    diff = rem - {1'b0, dvs};
    ge   = (rem >= {1'b0, dvs});
  end

  // Quotient lies in [0.5,2): renormalize, then truncate the spare low bit.
  always_comb begin
    mant    = q[QB-1] ? q[QB-2:1] : q[QB-3:0];
    exp_adj = q[QB-1] ? exp_q : exp_q - SE'(1);
    res_nx  = {sign_q, exp_adj[EXP_W-1:0], mant};
    ovf_nx  = 1'b0;
    unf_nx  = 1'b0;
    dz_nx   = 1'b0;
    if (z2_q) begin
      res_nx = {sign_q, EONES, MZERO};
      dz_nx  = 1'b1;
    end else if (z1_q) begin
      res_nx = {sign_q, EZERO, MZERO};
    end else if (!exp_adj[SE-1] && (exp_adj >= EMAXV)) begin
      res_nx = {sign_q, EONES, MZERO};
      ovf_nx = 1'b1;
    end else if (exp_adj[SE-1] || (exp_adj == '0)) begin
      res_nx = {sign_q, EZERO, MZERO};
      unf_nx = 1'b1;
    end
`ifdef FP_DIV_SPECIAL_EN
    if (spec_q) begin
      res_nx = spec_res;
      ovf_nx = 1'b0;
      unf_nx = 1'b0;
      dz_nx  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1       <= '0;
      op2       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      dvs       <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
      z1_q      <= 1'b0;
      z2_q      <= 1'b0;
      done_q    <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      div_zero  <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      spec_q    <= 1'b0;
      spec_res  <= '0;
`endif
    end else begin
      done_q <= fin;
      if (accept) begin
        op1       <= operand1;
        op2       <= operand2;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        div_zero  <= 1'b0;
      end
      if (ld_prep) begin
        sign_q <= op1[W-1] ^ op2[W-1];
        exp_q  <= exp_prep;
        dvs    <= m2n;
        rem    <= {1'b0, m1n};
        q      <= '0;
        z1_q   <= z1;
        z2_q   <= z2;
`ifdef FP_DIV_SPECIAL_EN
        // Specials pass through DIV once; that quotient is discarded in POST.
        spec_q   <= spec_hit;
        spec_res <= spec_val;
        cnt      <= spec_hit ? '0 : CW'(QB - 1);
`else
        cnt    <= CW'(QB - 1);
`endif
      end
      if (step) begin
        rem <= (ge ? diff : rem) << 1;
        q   <= {q[QB-2:0], ge};
        cnt <= cnt - CW'(1);
      end
      if (fin) begin
        result    <= res_nx;
        overflow  <= ovf_nx;
        underflow <= unf_nx;
        div_zero  <= dz_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Scoreboard bench for fp_divider_seq: directed vectors, latency and handshake checks.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        busy, done, overflow, underflow, div_zero;
  logic [31:0] result;

  fp_divider_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_result"}, 64'(result), 64'(e.res));
        chk({e.name, "_flags"}, 64'({overflow, underflow, div_zero}), 64'(e.flg));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Call away from a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [2:0] f, input int unsigned lat, input string nm,
                       input bit expect_it);
    exp_t e;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    if (expect_it) begin
      e.res  = r;
      e.flg  = f;
      e.due  = cyc + lat;
      e.name = nm;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got %0d pending results expected 0", sbq.size());
    sbq.delete();
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                     input logic [2:0] f, input string nm);
    @(negedge clk);
    issue(a, b, r, f, 27, nm, 1'b1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({busy, done, result, overflow, underflow, div_zero}), 64'd0);
    rst_n = 1'b1;

    // flags packed as {overflow, underflow, div_zero}
    run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, "six_by_two");
    run(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA, 3'b000, "neg_third");
    run(32'h0040_0000, 32'h3F00_0000, 32'h0080_0000, 3'b000, "subnormal");
    run(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, "one_by_one");
    run(32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 3'b010, "underflow");
    run(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, "div_zero");
    run(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, "zero_dividend");
    run(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000, "negzero_dividend");
    run(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 3'b000, "zero_by_neg");

`ifdef FP_DIV_SPECIAL_EN
    @(negedge clk);
    issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b000, 3, "zero_by_zero", 1'b1);
    wait_idle();
`else
    run(32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, "zero_by_zero");
`endif

    // start held high while busy: only the first request may run
    @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27, "held_start", 1'b1);
    operand1 = 32'h3F80_0000;
    operand2 = 32'h0000_0000;
    start    = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // back-to-back: second start lands in the done cycle of the first
    @(negedge clk);
    issue(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA, 3'b000, 27, "b2b_first", 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = done;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL b2b_wait: got no done expected done within 60 cycles");
      end
    end
    issue(32'h0040_0000, 32'h3F00_0000, 32'h0080_0000, 3'b000, 27, "b2b_second", 1'b1);
    wait_idle();

    // leave non-zero state behind, then abort an operation with reset
    run(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b100, "overflow");
    @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000, 32'h0, 3'b000, 27, "aborted", 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_abort", 64'({busy, done, result, overflow, underflow, div_zero}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_busy", 64'(busy), 64'd0);

    run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, "after_reset");

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
